// File: rtl/prog_clk_div.sv
// Programmable clock divider: registered divided clock, per-period tick, and a
// glitch-free divisor update that only lands on a period boundary or an idle edge.
module prog_clk_div #(
    parameter int WIDTH     = 16,
    parameter int RESET_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             div_ack,
    output logic             div_err,
    output logic             busy,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] RESET_D = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic wrap;
    logic rise;
    logic apply;

    // A divisor applied while idle can leave cnt above the new D-1; the >=
    // compare folds that back into a clean wrap at the next enabled edge.
    assign wrap  = (cnt_q >= (d_q - ONE));
    assign rise  = (cnt_q == ((d_q >> 1) - ONE));
    assign apply = valid_q && (sync_clr || !en || wrap);

    always_comb begin
        d_d       = d_q;
        p_d       = p_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        ack_d     = 1'b0;
        err_d     = 1'b0;

        if (sync_clr) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                tick_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
                if (rise) begin
                    clk_out_d = 1'b1;
                end
            end
        end

        if (apply) begin
            d_d     = p_q;
            valid_d = 1'b0;
            ack_d   = 1'b1;
        end

        // A load on the apply edge becomes the next pending value.
        if (div_load) begin
            if (div_in >= TWO) begin
                p_d     = div_in;
                valid_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q       <= RESET_D;
            p_q       <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            d_q       <= d_d;
            p_q       <= p_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign div_ack = ack_q;
    assign div_err = err_q;
    assign busy    = valid_q;
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_prog_clk_div.sv
// Bench for prog_clk_div: vector table, directed corner sequences, and random
// stimulus compared every cycle against a rule-level reference model.
module tb_prog_clk_div;

    localparam int W  = 16;
    localparam int RD = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         sync_clr;
    logic [W-1:0] div_in;
    logic         div_load;
    logic         clk_out;
    logic         tick;
    logic         div_ack;
    logic         div_err;
    logic         busy;
    logic [W-1:0] cnt;

    prog_clk_div #(.WIDTH(W), .RESET_DIV(RD)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .sync_clr (sync_clr),
        .div_in   (div_in),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .busy     (busy),
        .cnt      (cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state, expressed directly in divider terms.
    int m_d, m_p, m_cnt;
    int m_valid, m_clk, m_tick, m_ack, m_err;

    typedef struct {
        int en, clr, load, din;
        int e_clk, e_tick, e_ack, e_err, e_busy, e_cnt;
    } vec_t;
    vec_t vq[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_d = RD; m_p = 0; m_valid = 0; m_cnt = 0;
        m_clk = 0; m_tick = 0; m_ack = 0; m_err = 0;
    endtask

    task automatic model_step(input int e, input int c, input int l, input int din);
        int low_len;
        int at_wrap;
        int do_apply;
        low_len  = m_d / 2;
        at_wrap  = (e != 0) && (c == 0) && (m_cnt >= m_d - 1);
        do_apply = m_valid && ((c != 0) || (e == 0) || at_wrap);
        m_tick = 0; m_ack = 0; m_err = 0;
        if (c != 0) begin
            m_cnt = 0; m_clk = 0;
        end else if (e != 0) begin
            if (at_wrap) begin
                m_cnt = 0; m_clk = 0; m_tick = 1;
            end else begin
                if (m_cnt == low_len - 1) m_clk = 1;
                m_cnt = m_cnt + 1;
            end
        end
        if (do_apply) begin
            m_d = m_p; m_valid = 0; m_ack = 1;
        end
        if (l != 0) begin
            if (din >= 2) begin
                m_p = din; m_valid = 1;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, " clk_out"}, clk_out, m_clk);
        check({tag, " tick"},    tick,    m_tick);
        check({tag, " div_ack"}, div_ack, m_ack);
        check({tag, " div_err"}, div_err, m_err);
        check({tag, " busy"},    busy,    m_valid);
        check({tag, " cnt"},     cnt,     m_cnt);
    endtask

    task automatic cycle(input int e, input int c, input int l, input int din, input string tag);
        en       = (e != 0);
        sync_clr = (c != 0);
        div_load = (l != 0);
        div_in   = din[W-1:0];
        model_step(e, c, l, din);
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " clk_out"}, clk_out, 0);
        check({tag, " tick"},    tick,    0);
        check({tag, " div_ack"}, div_ack, 0);
        check({tag, " div_err"}, div_err, 0);
        check({tag, " busy"},    busy,    0);
        check({tag, " cnt"},     cnt,     0);
    endtask

    task automatic do_reset(input string tag);
        en = 1'b0; sync_clr = 1'b0; div_load = 1'b0; div_in = '0;
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic add_vec(input int e, c, l, din, e_clk, e_tick, e_ack, e_err, e_busy, e_cnt);
        vec_t v;
        v.en = e; v.clr = c; v.load = l; v.din = din;
        v.e_clk = e_clk; v.e_tick = e_tick; v.e_ack = e_ack;
        v.e_err = e_err; v.e_busy = e_busy; v.e_cnt = e_cnt;
        vq.push_back(v);
    endtask

    initial begin
        //        en clr ld din  clk tick ack err busy cnt
        add_vec(1, 0, 0, 0,   1, 0, 0, 0, 0, 1);  // D=2 toggling
        add_vec(1, 0, 0, 0,   0, 1, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0,   1, 0, 0, 0, 0, 1);
        add_vec(1, 0, 1, 5,   0, 1, 0, 0, 1, 0);  // load 5 on a wrap edge
        add_vec(1, 0, 0, 0,   1, 0, 0, 0, 1, 1);
        add_vec(1, 0, 0, 0,   0, 1, 1, 0, 0, 0);  // applied at next wrap
        add_vec(1, 0, 0, 0,   0, 0, 0, 0, 0, 1);  // D=5: low 2, high 3
        add_vec(1, 0, 0, 0,   1, 0, 0, 0, 0, 2);
        add_vec(1, 0, 0, 0,   1, 0, 0, 0, 0, 3);
        add_vec(1, 0, 0, 0,   1, 0, 0, 0, 0, 4);
        add_vec(1, 0, 0, 0,   0, 1, 0, 0, 0, 0);
        add_vec(1, 0, 1, 1,   0, 0, 0, 1, 0, 1);  // rejected loads
        add_vec(1, 0, 1, 0,   1, 0, 0, 1, 0, 2);
        add_vec(1, 0, 0, 0,   1, 0, 0, 0, 0, 3);
        add_vec(1, 0, 0, 0,   1, 0, 0, 0, 0, 4);
        add_vec(1, 0, 0, 0,   0, 1, 0, 0, 0, 0);  // D still 5

        model_reset();
        do_reset("reset");
        foreach (vq[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            cycle(vq[i].en, vq[i].clr, vq[i].load, vq[i].din, t);
            check({t, " exp clk_out"}, clk_out, vq[i].e_clk);
            check({t, " exp tick"},    tick,    vq[i].e_tick);
            check({t, " exp div_ack"}, div_ack, vq[i].e_ack);
            check({t, " exp div_err"}, div_err, vq[i].e_err);
            check({t, " exp busy"},    busy,    vq[i].e_busy);
            check({t, " exp cnt"},     cnt,     vq[i].e_cnt);
        end

        // D=4, enable dropped for 3 cycles at cnt=2
        do_reset("hold rst");
        cycle(0, 0, 1, 4, "hold ld");
        check("hold busy", busy, 1);
        cycle(0, 0, 0, 0, "hold apply");
        check("hold ack", div_ack, 1);
        cycle(1, 0, 0, 0, "hold c1");
        cycle(1, 0, 0, 0, "hold c2");
        check("hold cnt2", cnt, 2);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, "hold off");
            check("hold frozen cnt", cnt, 2);
            check("hold frozen tick", tick, 0);
        end
        cycle(1, 0, 0, 0, "hold c3");
        check("hold resume cnt", cnt, 3);
        cycle(1, 0, 0, 0, "hold wrap");
        check("hold wrap cnt", cnt, 0);
        check("hold wrap tick", tick, 1);

        // D=6 at cnt=4 with 3 pending, then sync_clr
        do_reset("clr rst");
        cycle(0, 0, 1, 6, "clr ld6");
        cycle(0, 0, 0, 0, "clr apply6");
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, "clr run");
        cycle(1, 0, 1, 3, "clr ld3");
        check("clr cnt4", cnt, 4);
        check("clr busy", busy, 1);
        cycle(1, 1, 0, 0, "clr edge");
        check("clr cnt", cnt, 0);
        check("clr clk_out", clk_out, 0);
        check("clr ack", div_ack, 1);
        check("clr busy after", busy, 0);
        cycle(1, 0, 0, 0, "clr d3 a");
        cycle(1, 0, 0, 0, "clr d3 b");
        cycle(1, 0, 0, 0, "clr d3 wrap");
        check("clr d3 tick", tick, 1);

        // Asynchronous reset at cnt=3 with a load pending
        do_reset("ar rst");
        cycle(0, 0, 1, 8, "ar ld8");
        cycle(0, 0, 0, 0, "ar apply8");
        cycle(1, 0, 0, 0, "ar c1");
        cycle(1, 0, 0, 0, "ar c2");
        cycle(1, 0, 1, 5, "ar ld5");
        check("ar cnt3", cnt, 3);
        check("ar busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("ar async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        cycle(1, 0, 0, 0, "ar post a");
        check("ar post clk_out", clk_out, 1);
        cycle(1, 0, 0, 0, "ar post b");
        check("ar post tick", tick, 1);
        check("ar post no ack", div_ack, 0);

        // Random stimulus against the model
        do_reset("rnd rst");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset("rnd mid rst");
            end else begin
                cycle(($urandom_range(0, 3) != 0) ? 1 : 0,
                      ($urandom_range(0, 19) == 0) ? 1 : 0,
                      ($urandom_range(0, 7) == 0) ? 1 : 0,
                      int'($urandom_range(0, 9)),
                      "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 Parameter WIDTH, default 16: width of divisor and counter.
REQ-002 Parameter RESET_DIV, default 2: divisor after reset; SHALL be in the range 2..2^WIDTH-1.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  count enable; 0 = hold all state.
REQ-006 sync_clr  input  1  synchronous restart of the division period.
REQ-007 div_in  input  WIDTH  requested divisor D.
REQ-008 div_load  input  1  one-cycle strobe; requests divisor update from div_in.
REQ-009 clk_out  output  1  divided clock, period D cycles, registered.
REQ-010 tick  output  1  one-cycle enable pulse per period, registered.
REQ-011 div_ack  output  1  one-cycle pulse when a pending divisor takes effect.
REQ-012 div_err  output  1  one-cycle pulse when a load request is rejected.
REQ-013 busy  output  1  pending divisor held and not yet applied.
REQ-014 cnt  output  WIDTH  current phase counter value.

Function
REQ-015 State: active divisor D, pending divisor P with valid bit, counter cnt in 0..D-1, and registers clk_out and tick.
REQ-016 Low-phase length L = floor(D/2); high phase = D-L cycles.
REQ-017 Enabled edge (en=1, sync_clr=0), when cnt==D-1: cnt<=0, clk_out<=0, tick<=1.
REQ-018 Enabled edge, when cnt==L-1 (and cnt!=D-1): cnt<=cnt+1, clk_out<=1, tick<=0.
REQ-019 Any other enabled edge: cnt<=cnt+1; clk_out holds; tick<=0.
REQ-020 en=0 with sync_clr=0: cnt and clk_out hold; tick<=0.
REQ-021 sync_clr=1 (overrides en): cnt<=0, clk_out<=0, tick<=0; D and P are unchanged.
REQ-022 div_load=1 with div_in>=2: P<=div_in and valid<=1; a second load while pending overwrites P.
REQ-023 div_load=1 with div_in<2: request ignored; div_err<=1 for one cycle; existing P is unchanged.
REQ-024 Pending P is applied (D<=P, valid<=0, div_ack<=1) only at an enabled wrap edge (cnt==D-1), at an edge with en=0, or at a sync_clr edge.
REQ-025 Capture takes one edge: a div_load coinciding with a wrap edge is applied at the next qualifying edge, never at the same edge.
REQ-026 div_load coinciding with an apply edge: the old P is applied and acknowledged, and the new value becomes pending.
REQ-027 busy = valid; div_ack and div_err are otherwise 0.
REQ-028 No glitches or runt pulses: clk_out changes only per REQ-017/018/021, and period changes happen only at a period boundary.
REQ-029 D=2 behaviour: clk_out toggles every enabled cycle, and tick fires every 2nd cycle.

Reset
REQ-030 On reset: D=RESET_DIV, valid=0, cnt=0, clk_out=0, tick=0, div_ack=0, div_err=0, busy=0.
REQ-031 Reset asserted mid-period or with a load pending: pending value discarded; state returns to REQ-030 immediately, without waiting for a clock edge.

Verification
REQ-032 Reset release, en=1, D=2 -> clk_out 0,1,0,1…; tick every 2nd cycle, coincident with clk_out falling.
REQ-033 Load 5, en=1 -> busy=1 until wrap; div_ack at wrap; then clk_out low 2, high 3 cycles; tick period 5.
REQ-034 Load 1 then load 0 -> div_err pulses twice; D unchanged; busy stays 0.
REQ-035 D=4, en=0 for 3 cycles at cnt=2 -> cnt holds at 2 and tick stays 0; counting resumes 3,0 with tick at the wrap.
REQ-036 D=6, cnt=4, sync_clr pulse with load 3 pending -> cnt=0, clk_out=0, D=3, div_ack=1 on the same edge.
REQ-037 Reset asserted at cnt=3 with busy=1 -> all outputs per REQ-030 asynchronously; D=RESET_DIV.
